pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the MIPS-32 datapath. It replaces the fixed-width, always-enabled inter-stage flops (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that has a valid/ready handshake, a flush, and a saturating stall-cycle counter. It sits between two pipeline stages and carries the concatenated control and data bundle. A compile-time option adds a skid buffer so that `in_ready` is fully registered.

---
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid register so that in_ready comes straight from state.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 147,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             accept;
  logic             consume;
  logic             valid_q;
  logic [WIDTH-1:0] main_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign accept    = in_valid & in_ready;
  assign consume   = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

  // Only reset clears the counter; a flush leaves the stall history intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] skid_q;

  assign in_ready = (state_q != StSkid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (accept && consume) begin
            main_q <= in_data;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind the held one.
            skid_q  <= in_data;
            state_q <= StSkid;
          end else if (consume) begin
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StSkid: begin
          if (consume) begin
            main_q  <= skid_q;
            state_q <= StFull;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`else

  assign in_ready = out_ready | ~valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (accept) begin
      main_q  <= in_data;
      valid_q <= 1'b1;
    end else if (consume) begin
      // Payload is left in place; only the valid bit drops.
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned W = 147;
  localparam int unsigned C = 16;
`ifdef PIPE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [C-1:0] stall_cnt;

  logic       flush_s = 1'b0;
  logic       in_valid_s = 1'b0;
  logic       in_ready_s;
  logic [7:0] in_data_s = '0;
  logic       out_valid_s;
  logic       out_ready_s = 1'b1;
  logic [7:0] out_data_s;
  logic [2:0] stall_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: beats held, last payload shown, expected stall count.
  logic [W-1:0] q[$];
  logic [W-1:0] last = '0;
  logic [C-1:0] exp_stall = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_s),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .in_data   (in_data_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out_data  (out_data_s),
    .stall_cnt (stall_cnt_s)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit model_ready(input logic ordy);
    if (Skid) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  function automatic logic [W-1:0] model_data();
    if (q.size() > 0) return q[0];
    return last;
  endfunction

  function automatic void model_edge(input logic iv, input logic [W-1:0] d, input logic ordy,
                                     input logic fl);
    bit acc;
    bit con;
    acc = iv && model_ready(ordy);
    con = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
    if (fl) begin
      q.delete();
      last = '0;
    end else begin
      if (con) last = q.pop_front();
      if (acc) q.push_back(d);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    last      = '0;
    exp_stall = '0;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Called at a negedge: drive, check in_ready, clock once, check registered outputs.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("in_ready", in_ready, model_ready(ordy));
    @(posedge clk);
    model_edge(iv, d, ordy, fl);
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, model_data());
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  initial begin
    logic [C-1:0] s_before;

    // Reset state, with in_ready high for either out_ready value.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    out_ready = 1'b0;
    #1;
    check("rst_in_ready_or0", in_ready, 1);
    out_ready = 1'b1;
    #1;
    check("rst_in_ready_or1", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Stream 1,2,3 at full rate.
    step(1'b1, W'(1), 1'b1, 1'b0);
    check("stream_d1", out_data, W'(1));
    step(1'b1, W'(2), 1'b1, 1'b0);
    check("stream_d2", out_data, W'(2));
    step(1'b1, W'(3), 1'b1, 1'b0);
    check("stream_d3", out_data, W'(3));
    check("stream_valid", out_valid, 1);
    check("stream_stall", stall_cnt, 0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: four stalled cycles with a beat held.
    step(1'b1, W'(10), 1'b0, 1'b0);
    step(1'b1, W'(11), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("bp_stall4", stall_cnt, 4);
    check("bp_data_stable", out_data, W'(10));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush wins over a simultaneous accept of 0xA5.
    step(1'b1, W'(20), 1'b1, 1'b0);
    s_before = stall_cnt;
    step(1'b1, W'('hA5), 1'b1, 1'b1);
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    check("flush_stall", stall_cnt, s_before);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_a5", out_data, 0);

    // Counter saturation on the 3-bit instance.
    in_valid_s  = 1'b1;
    in_data_s   = 8'h5A;
    out_ready_s = 1'b0;
    @(negedge clk);
    in_valid_s = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("sat_at7", W'(stall_cnt_s), 7);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("sat_hold7", W'(stall_cnt_s), 7);
    check("sat_data", W'(out_data_s), W'(8'h5A));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, rand_data(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    // Async reset between edges with the block as full as it gets.
    step(1'b1, rand_data(), 1'b0, 1'b0);
    step(1'b1, rand_data(), 1'b0, 1'b0);
    step(1'b1, rand_data(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("areset_valid", out_valid, 0);
    check("areset_data", out_data, 0);
    check("areset_stall", stall_cnt, 0);
    check("areset_sat_stall", W'(stall_cnt_s), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("areset_in_ready", in_ready, 1);
    @(negedge clk);
    step(1'b1, W'(42), 1'b1, 1'b0);
    check("post_reset_d", out_data, W'(42));
    step(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
